sync_fifo_ff: RTL and testbench

SYNC_FIFO_FF -- requirements
Module: sync_fifo_ff

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 23 ++
 rtl/sync_fifo_ff.sv | 113 +++++++++++
 tb/tb_sync_fifo_ff.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer sizing and reset constants for the synchronous FIFO
package fifo_pkg;

  // Pointer carries one extra wrap bit above the entry index.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam logic RST_EMPTY    = 1'b1;
  localparam logic RST_FULL     = 1'b0;
  localparam logic RST_AEMPTY   = 1'b1;
  localparam logic RST_AFULL    = 1'b0;
  localparam logic RST_PULSE    = 1'b0;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping FIFO pointer register with wrap bit and asynchronous reset
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_nxt
);

  // Natural binary overflow wraps the index and toggles the MSB together.
  assign ptr_nxt = ptr + {{(W-1){1'b0}}, inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/sync_fifo_ff.sv
// rtl/sync_fifo_ff.sv - single-clock FIFO with registered read port and status flags
// Optional almost_full/almost_empty ports are built when SYNC_FIFO_ALMOST_EN is defined.
module sync_fifo_ff
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`ifdef SYNC_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || DEPTH > 256 ||
      AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_param
    $error("sync_fifo_ff: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     wr_nxt;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_nxt;
  logic              wr_ok;
  logic              rd_ok;
  logic              full_nxt;
  logic              empty_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  // A write into a full FIFO is legal only when a read frees a slot this same edge.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .inc     (wr_ok),
    .ptr     (wr_ptr),
    .ptr_nxt (wr_nxt)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .inc     (rd_ok),
    .ptr     (rd_ptr),
    .ptr_nxt (rd_nxt)
  );

  assign empty_nxt = (wr_nxt == rd_nxt);
  assign full_nxt  = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);

  // Storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data   <= '0;
      rd_valid  <= RST_PULSE;
      overflow  <= RST_PULSE;
      underflow <= RST_PULSE;
      full      <= RST_FULL;
      empty     <= RST_EMPTY;
    end else begin
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
      rd_valid  <= rd_ok;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && !rd_ok;
      full      <= full_nxt;
      empty     <= empty_nxt;
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  logic [PW-1:0] occ_nxt;

  assign occ_nxt = wr_nxt - rd_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full  <= RST_AFULL;
      almost_empty <= RST_AEMPTY;
    end else begin
      almost_full  <= ({1'b0, occ_nxt} >= (PW + 1)'(AF_LEVEL));
      almost_empty <= ({1'b0, occ_nxt} <= (PW + 1)'(AE_LEVEL));
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ff.sv
// tb/tb_sync_fifo_ff.sv - randomized self-checking bench for sync_fifo_ff against a queue model
module tb_sync_fifo_ff;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = DEPTH - 2;
  localparam int AE_LVL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;
`ifdef SYNC_FIFO_ALMOST_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int wr_acc;
  int rd_acc;
  int cyc;
  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] last_rd;

  sync_fifo_ff #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LVL),
    .AE_LEVEL (AE_LVL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit exp_rv, input bit exp_ov, input bit exp_un);
    int n;
    n = model_q.size();
    check("rd_valid",  32'(rd_valid),  32'(exp_rv));
    check("rd_data",   32'(rd_data),   32'(last_rd));
    check("full",      32'(full),      32'(n == DEPTH));
    check("empty",     32'(empty),     32'(n == 0));
    check("overflow",  32'(overflow),  32'(exp_ov));
    check("underflow", 32'(underflow), 32'(exp_un));
`ifdef SYNC_FIFO_ALMOST_EN
    check("almost_full",  32'(almost_full),  32'(n >= AF_LVL));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE_LVL));
`endif
  endtask

  // One clock of stimulus; acceptance is decided from queue occupancy before the edge.
  task automatic step(input bit wr, input logic [DATA_W-1:0] wd, input bit rd);
    bit acc_wr;
    bit acc_rd;
    int n;
    @(negedge clk);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    n       = model_q.size();
    acc_rd  = rd && (n > 0);
    acc_wr  = wr && ((n < DEPTH) || acc_rd);
    @(posedge clk);
    #1;
    if (acc_rd) last_rd = model_q.pop_front();
    if (acc_wr) model_q.push_back(wd);
    wr_acc += int'(acc_wr);
    rd_acc += int'(acc_rd);
    check_outputs(acc_rd, wr && !acc_wr, rd && !acc_rd);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    last_rd = '0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    wr_acc  = 0;
    rd_acc  = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_outputs(0, 0, 0);
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    check_outputs(0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    check("full_after_fill", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0);

    // Drain in order, then read from empty.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_order", 32'(rd_data), 32'(8'h11 + i));
    end
    step(1'b0, 8'h00, 1'b1);
    check("underflow_hold", 32'(rd_data), 32'h18);

    // Simultaneous read and write at full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h21 + i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    check("rw_full_oldest", 32'(rd_data), 32'h21);
    check("rw_full_stays",  32'(full),    32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    check("rw_full_last", 32'(rd_data), 32'h55);

    // Write while empty with read: write only, no bypass.
    step(1'b1, 8'h66, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // 20 writes interleaved with 20 reads across pointer wrap.
    wr_acc = 0;
    rd_acc = 0;
    cyc    = 0;
    while ((wr_acc < 20 || rd_acc < 20) && cyc < 400) begin
      step(bit'(wr_acc < 20 && $urandom_range(0, 1) != 0), 8'($urandom),
           bit'(rd_acc < 20 && $urandom_range(0, 1) != 0));
      cyc++;
    end
    check("interleave_done", 32'(wr_acc == 20 && rd_acc == 20), 32'd1);

    // Random soak.
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 99) < 55), 8'($urandom), bit'($urandom_range(0, 99) < 50));
    end

    // Reset mid-stream with five entries stored.
    while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
    #2;
    reset = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    model_reset();
    check_outputs(0, 0, 0);
    @(posedge clk);
    #1;
    check_outputs(0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    check("post_reset_underflow", 32'(underflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
